// File: rtl/timer_ctrl_if.sv
// Peripheral-bus slave interface for timer_ctrl.
//   master modport: drives sel/we/addr/wdata, receives rdata/rvalid (CPU side)
//   slave  modport: receives sel/we/addr/wdata, drives rdata/rvalid (timer side)
//   sel    slave select          we     1=write, 0=read
//   addr   register index (3b)   wdata  write data (CPU_WIDTH)
//   rdata  registered read data  rvalid 1 cycle after a read access
interface timer_ctrl_if #(
  parameter int CPU_WIDTH = 16
);
  logic                 sel;
  logic                 we;
  logic [2:0]           addr;
  logic [CPU_WIDTH-1:0] wdata;
  logic [CPU_WIDTH-1:0] rdata;
  logic                 rvalid;

  modport master (output sel, we, addr, wdata, input  rdata, rvalid);
  modport slave  (input  sel, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/timer_ctrl.sv
// Bus-mapped interval timer controller: programmable period, periodic or
// one-shot counting, sticky expiry flag turned into a level interrupt.
// Ports:
//   clk  system clock (posedge)       rst  synchronous reset, active-high
//   bus  timer_ctrl_if.slave (sel, we, addr, wdata, rdata, rvalid)
//   irq  registered level interrupt = PEND & IE
// Registers: 0 CTRL {IE,ONESHOT,EN}, 1 PERIOD, 2 COUNT (ro),
//   3 STATUS {RUNNING(ro), PEND(w1c)}, 4 PRESC (prescaler build only).
// Build option: define TIMER_CTRL_PRESCALER_EN to add the 8-bit prescaler
//   (tick once every PRESC+1 clocks in RUN); otherwise tick every clock.
module timer_ctrl #(
  parameter int CPU_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  timer_ctrl_if.slave  bus,
  output logic         irq
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CPU_WIDTH-1:0] ONE = {{(CPU_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic                 en, oneshot, ie, pend;
  logic [CPU_WIDTH-1:0] period, count;
  logic [CPU_WIDTH-1:0] rmux;
  logic                 rd, wr_ctrl, wr_period, wr_status, stop, tick, expire;

  assign rd        = bus.sel & ~bus.we;
  assign wr_ctrl   = bus.sel & bus.we & (bus.addr == 3'd0);
  assign wr_period = bus.sel & bus.we & (bus.addr == 3'd1);
  assign wr_status = bus.sel & bus.we & (bus.addr == 3'd3);
  // A CTRL write clearing EN takes priority over the tick of the same cycle.
  assign stop      = wr_ctrl & ~bus.wdata[0];
  // Compare against the registered PERIOD: a PERIOD written below COUNT
  // expires on the following tick instead of wrapping.
  assign expire    = tick & ~stop & (count >= period);

`ifdef TIMER_CTRL_PRESCALER_EN
  logic       wr_presc;
  logic [7:0] presc, pcnt;

  assign wr_presc = bus.sel & bus.we & (bus.addr == 3'd4);
  assign tick     = (state == RUN) && (pcnt == presc);

  // Entry to RUN only happens through a CTRL write, so clearing on CTRL
  // writes also covers the clear-on-entry case.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      pcnt  <= '0;
    end else begin
      if (wr_presc) presc <= bus.wdata[7:0];
      if (wr_ctrl || wr_period || wr_presc) pcnt <= '0;
      else if (state == RUN)                pcnt <= tick ? 8'd0 : pcnt + 8'd1;
    end
  end
`else
  assign tick = (state == RUN);
`endif

  always_comb begin
    rmux = '0;
    case (bus.addr)
      3'd0: rmux[2:0] = {ie, oneshot, en};
      3'd1: rmux      = period;
      3'd2: rmux      = count;
      3'd3: rmux[1:0] = {state == RUN, pend};
`ifdef TIMER_CTRL_PRESCALER_EN
      3'd4: rmux[7:0] = presc;
`endif
      default: rmux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      en         <= 1'b0;
      oneshot    <= 1'b0;
      ie         <= 1'b0;
      pend       <= 1'b0;
      period     <= '0;
      count      <= '0;
      irq        <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= rd;
      if (rd) bus.rdata <= rmux;
      irq <= pend & ie;

      if (wr_ctrl) begin
        en      <= bus.wdata[0];
        oneshot <= bus.wdata[1];
        ie      <= bus.wdata[2];
      end
      if (wr_period) period <= bus.wdata;

      // Set wins over a same-cycle write-1-to-clear.
      if (expire)                       pend <= 1'b1;
      else if (wr_status && bus.wdata[0]) pend <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (wr_ctrl && bus.wdata[0]) begin
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (tick) begin
            if (count >= period) begin
              count <= '0;
              if (oneshot) begin
                state <= DONE;
                en    <= 1'b0;  // overrides a same-cycle CTRL write of EN
              end
            end else begin
              count <= count + ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;
  localparam int W = 16;
`ifdef TIMER_CTRL_PRESCALER_EN
  localparam bit HAS_PRESC = 1'b1;
`else
  localparam bit HAS_PRESC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic irq;

  timer_ctrl_if #(.CPU_WIDTH(W)) bus ();
  timer_ctrl #(.CPU_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus), .irq(irq));

  always #5 clk = ~clk;

  typedef struct {
    bit           rv;
    logic [W-1:0] rd;
    bit           irq;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: timer described by its observable rules.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t       m_mode;
  bit          m_os, m_ie, m_pend;
  int unsigned m_period, m_count, m_presc, m_pc;

  function automatic logic [W-1:0] model_read(input int unsigned a);
    int unsigned v;
    case (a)
      0: v = (m_ie ? 4 : 0) + (m_os ? 2 : 0) + ((m_mode == M_RUN) ? 1 : 0);
      1: v = m_period;
      2: v = m_count;
      3: v = ((m_mode == M_RUN) ? 2 : 0) + (m_pend ? 1 : 0);
      4: v = HAS_PRESC ? m_presc : 0;
      default: v = 0;
    endcase
    return v[W-1:0];
  endfunction

  function automatic void model_step(input bit r, input bit s, input bit w,
                                     input int unsigned a, input int unsigned d);
    bit wc, wp, ws, wpr, stop, tick, expire;
    mode_t old_mode;
    if (r) begin
      m_mode = M_IDLE; m_os = 0; m_ie = 0; m_pend = 0;
      m_period = 0; m_count = 0; m_presc = 0; m_pc = 0;
      return;
    end
    wc  = s && w && (a == 0);
    wp  = s && w && (a == 1);
    ws  = s && w && (a == 3);
    wpr = s && w && (a == 4) && HAS_PRESC;
    stop = wc && (d % 2 == 0);
    tick = (m_mode == M_RUN) && (!HAS_PRESC || m_pc == m_presc);
    expire = tick && !stop && (m_count >= m_period);
    old_mode = m_mode;

    if (m_mode == M_RUN) begin
      if (stop) m_mode = M_IDLE;
      else if (tick) begin
        if (expire) begin
          m_count = 0;
          if (m_os) m_mode = M_DONE;
        end else m_count++;
      end
    end else if (wc && (d % 2 == 1)) begin
      m_mode = M_RUN;
      m_count = 0;
    end

    if (wc || wp || wpr) m_pc = 0;
    else if (old_mode == M_RUN) m_pc = tick ? 0 : m_pc + 1;

    if (wc) begin
      m_os = ((d / 2) % 2) == 1;
      m_ie = ((d / 4) % 2) == 1;
    end
    if (wp)  m_period = d % 65536;
    if (wpr) m_presc  = d % 256;
    if (expire)                m_pend = 1;
    else if (ws && (d % 2 == 1)) m_pend = 0;
  endfunction

  task automatic cycle(input bit r, input bit s, input bit w,
                       input int unsigned a, input int unsigned d);
    exp_t e;
    rst = r; bus.sel = s; bus.we = w; bus.addr = a[2:0]; bus.wdata = d[W-1:0];
    e.rv  = !r && s && !w;
    e.rd  = model_read(a);
    e.irq = !r && m_pend && m_ie;
    expq.push_back(e);
    model_step(r, s, w, a, d);
    @(posedge clk); #1;
  endtask

  task automatic wr(input int unsigned a, input int unsigned d); cycle(0, 1, 1, a, d); endtask
  task automatic rd(input int unsigned a);                       cycle(0, 1, 0, a, 0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expectation per clock and compares visible outputs.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard_underflow: got empty queue, required an entry");
      end else begin
        e = expq.pop_front();
        tests++;
        if (bus.rvalid !== e.rv) begin
          fails++;
          $display("FAIL rvalid @%0t: got %b required %b", $time, bus.rvalid, e.rv);
        end
        if (e.rv) begin
          tests++;
          if (bus.rdata !== e.rd) begin
            fails++;
            $display("FAIL rdata @%0t: got %0h required %0h", $time, bus.rdata, e.rd);
          end
        end
        tests++;
        if (irq !== e.irq) begin
          fails++;
          $display("FAIL irq @%0t: got %b required %b", $time, irq, e.irq);
        end
      end
    end
  end

  initial begin
    int unsigned op, d;
    model_step(1, 0, 0, 0, 0);
    // reset and reset-state readback
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 2, 0);
    for (int unsigned a = 0; a < 8; a++) rd(a);
    // periodic: PERIOD=4, EN|IE
    wr(1, 4); wr(0, 5);
    for (int i = 0; i < 12; i++) rd(2);
    rd(3); wr(3, 1); idle(3);
    // one-shot: PERIOD=2, EN|ONESHOT
    wr(0, 0); wr(3, 1); wr(1, 2); wr(0, 3);
    idle(5); rd(0); rd(2); rd(3); wr(3, 1); idle(6); rd(3);
    // W1C colliding with expiry
    wr(1, 3); wr(0, 5);
    for (int i = 0; i < 9; i++) wr(3, 1);
    rd(3); idle(2);
    // PERIOD lowered below COUNT, then PERIOD=0
    wr(1, 100); wr(0, 1); idle(9); wr(1, 3); rd(2); rd(3); rd(2);
    wr(1, 0); for (int i = 0; i < 4; i++) begin rd(2); wr(3, 1); end
    // reset mid-run with pending flag and reads in flight
    wr(0, 5); idle(2); rd(2); cycle(1, 1, 0, 3, 0); cycle(1, 0, 0, 0, 0);
    for (int unsigned a = 0; a < 5; a++) rd(a);
    // address 4 and prescaler behaviour
    wr(4, 16'hFFFF); rd(4); wr(4, 3); rd(4); wr(1, 1); wr(0, 5);
    for (int i = 0; i < 20; i++) begin rd(3); if (i % 4 == 3) wr(3, 1); end
    wr(0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 199);
      if (op < 2)        cycle(1, $urandom_range(0, 1), 0, 2, 0);
      else if (op < 70)  idle(1);
      else if (op < 120) rd($urandom_range(0, 7));
      else if (op < 145) wr(0, $urandom_range(0, 7) | ($urandom & 32'hFFF8));
      else if (op < 160) wr(1, $urandom_range(0, 12));
      else if (op < 180) wr(3, $urandom_range(0, 3));
      else if (op < 192) begin
        d = $urandom_range(0, 3) | ($urandom & 32'hFF00);
        wr(4, d);
      end else           wr($urandom_range(5, 7), $urandom);
    end
    idle(2);
    @(negedge clk); #1;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
